// File: rtl/wait_ram_pkg.sv
// Shared types and default parameters for the wait-state RAM.
// FSM state encoding plus the parameter defaults used by wait_ram and its storage array.
package wait_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W      = 15;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_DEPTH       = 32768;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/wait_ram_array.sv
// Single-port storage: synchronous write, registered read, out-of-range reads return 0.
// Latency 1 edge for both reads and writes; no backpressure, the caller strobes en_i.
module wait_ram_array
    import wait_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              oob_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Plain array with no reset so a simulator can peek contents by name.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i && !oob_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= oob_i ? '0 : mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wait_ram.sv
// RAM with programmable wait states: req/ready handshake, one-cycle ack WAIT_CYCLES+1 edges after accept.
// Backpressure: ready drops from acceptance until the response cycle has passed.
module wait_ram
    import wait_ram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               ack_q;
    logic               err_q;
    logic               accept;
    logic               access;
    logic               oob;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_L;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rst_n gates access so a reset landing on the access edge drops a pending write.
    always_comb begin
        ready  = (state_q == IDLE) && rst_n;
        accept = ready && req;
        access = (state_q == WAIT) && (cnt_q == '0) && rst_n;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign oob = ({1'b0, addr_q} >= DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= access;
            err_q <= access && oob;
        end
    end

    wait_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (access),
        .we_i    (we_q),
        .oob_i   (oob),
        .addr_i  (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    assign ack = ack_q;
    assign err = err_q;

endmodule

// File: tb/tb_wait_ram.sv
// Bench for wait_ram: three instances (1, 0 and 15 wait states), table vectors plus corner sequences.
// Expected responses are queued at acceptance and retired by a negedge monitor.
module tb_wait_ram;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, req2;
    logic        we0, we1, we2;
    logic [14:0] addr0, addr2;
    logic [7:0]  addr1;
    logic [7:0]  wd0, wd2;
    logic [15:0] wd1;
    wire  [2:0]  ready, ack, err;
    wire  [7:0]  rd0, rd2;
    wire  [15:0] rd1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          inst;
        int          due;
        logic [15:0] rd;
        logic        ee;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          inst;
        logic        w;
        logic [14:0] a;
        logic [15:0] d;
        logic [15:0] er;
        logic        ee;
    } vec_t;
    vec_t tbl[17];

    logic [14:0] salist[3];
    logic [15:0] sdlist[3];

    wait_ram #(.ADDR_W(15), .DATA_W(8), .DEPTH(1024), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wd0),
        .ready(ready[0]), .ack(ack[0]), .rdata(rd0), .err(err[0]));

    wait_ram #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wd1),
        .ready(ready[1]), .ack(ack[1]), .rdata(rd1), .err(err[1]));

    wait_ram #(.ADDR_W(15), .DATA_W(8), .DEPTH(32768), .WAIT_CYCLES(15)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we2), .addr(addr2), .wdata(wd2),
        .ready(ready[2]), .ack(ack[2]), .rdata(rd2), .err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [15:0] rdv(input int k);
        case (k)
            0:       return {8'h00, rd0};
            1:       return rd1;
            default: return {8'h00, rd2};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input int k, input logic r, input logic w,
                         input logic [14:0] a, input logic [15:0] d);
        case (k)
            0: begin req0 = r; we0 = w; addr0 = a;      wd0 = d[7:0]; end
            1: begin req1 = r; we1 = w; addr1 = a[7:0]; wd1 = d;      end
            default: begin req2 = r; we2 = w; addr2 = a; wd2 = d[7:0]; end
        endcase
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (!ready[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) begin
            total++;
            bad++;
            $display("FAIL ready_timeout inst=%0d: got ready=0 want 1", k);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got %0d pending want 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Inputs are scrambled right after acceptance; the access must use the captured values.
    task automatic do_access(input int k, input logic w, input logic [14:0] a,
                             input logic [15:0] d, input logic [15:0] er, input logic ee);
        exp_t e;
        wait_ready(k);
        drive(k, 1'b1, w, a, d);
        @(posedge clk);
        #1;
        e.inst = k;
        e.due  = cyc + wc(k) + 1;
        e.rd   = er;
        e.ee   = ee;
        sbq.push_back(e);
        drive(k, 1'b0, 1'($urandom), 15'($urandom), 16'($urandom));
        wait_drain();
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (ack[k]) begin
                if (sbq.size() != 0 && sbq[0].inst == k) begin
                    e = sbq.pop_front();
                    chk("ack_latency", 32'(cyc), 32'(e.due));
                    chk("rdata", {16'h0, rdv(k)}, {16'h0, e.rd});
                    chk("err", {31'h0, err[k]}, {31'h0, e.ee});
                end else begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack inst=%0d: got ack=1 want 0 (cycle %0d)", k, cyc);
                end
            end else if (sbq.size() != 0 && sbq[0].inst == k) begin
                chk("busy_ready", {31'h0, ready[k]}, 32'h0);
                if (cyc > sbq[0].due) begin
                    total++;
                    bad++;
                    $display("FAIL ack_late inst=%0d: got none by cycle %0d want cycle %0d", k, cyc, sbq[0].due);
                    sbq.delete(0);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{0, 1'b1, 15'h0010, 16'h00A5, 16'h0000, 1'b0};
        tbl[1]  = '{0, 1'b0, 15'h0010, 16'h0000, 16'h00A5, 1'b0};
        tbl[2]  = '{0, 1'b1, 15'h0020, 16'h0011, 16'h00A5, 1'b0};
        tbl[3]  = '{0, 1'b1, 15'h0000, 16'h005A, 16'h00A5, 1'b0};
        tbl[4]  = '{0, 1'b1, 15'h0400, 16'h003C, 16'h00A5, 1'b1};
        tbl[5]  = '{0, 1'b0, 15'h0400, 16'h0000, 16'h0000, 1'b1};
        tbl[6]  = '{0, 1'b0, 15'h0000, 16'h0000, 16'h005A, 1'b0};
        tbl[7]  = '{0, 1'b1, 15'h03FF, 16'h0099, 16'h005A, 1'b0};
        tbl[8]  = '{0, 1'b0, 15'h03FF, 16'h0000, 16'h0099, 1'b0};
        tbl[9]  = '{0, 1'b0, 15'h7FFF, 16'h0000, 16'h0000, 1'b1};
        tbl[10] = '{0, 1'b0, 15'h0020, 16'h0000, 16'h0011, 1'b0};
        tbl[11] = '{1, 1'b1, 15'h00FF, 16'hBEEF, 16'h0000, 1'b0};
        tbl[12] = '{1, 1'b0, 15'h00FF, 16'h0000, 16'hBEEF, 1'b0};
        tbl[13] = '{1, 1'b1, 15'h0001, 16'h1234, 16'hBEEF, 1'b0};
        tbl[14] = '{1, 1'b0, 15'h0001, 16'h0000, 16'h1234, 1'b0};
        tbl[15] = '{2, 1'b1, 15'h7FFF, 16'h00C3, 16'h0000, 1'b0};
        tbl[16] = '{2, 1'b0, 15'h7FFF, 16'h0000, 16'h00C3, 1'b0};
        salist[0] = 15'h0010; sdlist[0] = 16'h00A5;
        salist[1] = 15'h0000; sdlist[1] = 16'h005A;
        salist[2] = 15'h03FF; sdlist[2] = 16'h0099;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 15'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", {31'h0, ready[k]}, 32'h0);
            chk("rst_ack", {31'h0, ack[k]}, 32'h0);
            chk("rst_err", {31'h0, err[k]}, 32'h0);
            chk("rst_rdata", {16'h0, rdv(k)}, 32'h0);
        end

        // First request rides the very first edge after reset release.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 17; i++) begin
            do_access(tbl[i].inst, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee);
        end

        // req held high: one acceptance every WAIT_CYCLES+3 = 4 edges, addr toggling every cycle.
        wait_ready(0);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            if (i > 0) @(negedge clk);
            drive(0, 1'b1, 1'b0, salist[i % 3], 16'h0);
            if (i % 4 == 0) chk("stream_ready", {31'h0, ready[0]}, 32'h1);
            @(posedge clk);
            #1;
            if (i % 4 == 0) begin
                e.inst = 0;
                e.due  = cyc + 2;
                e.rd   = sdlist[i % 3];
                e.ee   = 1'b0;
                sbq.push_back(e);
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
        wait_drain();

        // Reset while waiting: the write of 0x77 must never land.
        wait_ready(0);
        drive(0, 1'b1, 1'b1, 15'h0020, 16'h0077);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rdata", {16'h0, rdv(0)}, 32'h0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_noack", {31'h0, ack[0]}, 32'h0);
        end
        do_access(0, 1'b0, 15'h0020, 16'h0, 16'h0011, 1'b0);
        chk("peek_0x20", {24'h0, u0.u_array.mem[32]}, 32'h11);

        // Reset during the response cycle keeps the committed write.
        do_access(0, 1'b1, 15'h0030, 16'h0042, 16'h0011, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("resp_rst_ack", {31'h0, ack[0]}, 32'h0);
        chk("resp_rst_rdata", {16'h0, rdv(0)}, 32'h0);
        chk("resp_rst_ready", {31'h0, ready[0]}, 32'h0);
        rst_n = 1'b1;
        do_access(0, 1'b0, 15'h0030, 16'h0, 16'h0042, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wait_ram.md
WAIT_RAM -- requirements
Module: wait_ram

Interface
REQ-001 Parameter ADDR_W, default 15, address bus width in bits.
REQ-002 Parameter DATA_W, default 8, data word width in bits.
REQ-003 Parameter DEPTH, default 32768, number of implemented words; legal range 1 .. 2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 1, extra wait states per access; legal range 0..15.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 req  input  1  access request, qualified by ready.
REQ-009 we  input  1  1 = write, 0 = read; sampled with req.
REQ-010 addr  input  ADDR_W  word address; sampled with req.
REQ-011 wdata  input  DATA_W  write data; sampled with req.
REQ-012 ready  output  1  block can accept a request this cycle.
REQ-013 ack  output  1  one-cycle completion strobe.
REQ-014 rdata  output  DATA_W  read data; valid while ack is high, held afterwards.
REQ-015 err  output  1  with ack: access addressed a word >= DEPTH.

Function
REQ-016 Acceptance SHALL occur on a rising edge where req=1, ready=1 and rst_n=1; we, addr and wdata are captured at that edge; req while ready=0 SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, WAIT and RESP; ready=1 only in IDLE with rst_n=1.
REQ-018 IDLE->WAIT on acceptance, with wait counter loaded with WAIT_CYCLES.
REQ-019 In WAIT, when counter != 0: decrement and stay; when counter == 0: perform the access, go to RESP.
REQ-020 ack SHALL be registered, high only in RESP, for exactly one cycle, starting WAIT_CYCLES+1 edges after the accepting edge.
REQ-021 RESP->IDLE unconditionally; minimum request spacing is WAIT_CYCLES+3 cycles.
REQ-022 Write: store[addr] <= wdata on the access edge; rdata unchanged.
REQ-023 Read: rdata <= store[addr] on the access edge; rdata SHALL hold until the next read's access edge.
REQ-024 addr >= DEPTH: write dropped, read returns rdata = 0; err=1 with ack; otherwise err=0.
REQ-025 Write followed by read of the same address SHALL return the newly written value.
REQ-026 Changes on we/addr/wdata after acceptance SHALL NOT affect the access in progress.
REQ-027 Storage contents SHALL be uninitialised at power-up and unaffected by reset.

Reset
REQ-028 While rst_n=0 at an edge: state=IDLE, counter=0, ack=0, err=0, rdata=0; ready=0 while rst_n=0.
REQ-029 Reset in WAIT before the access edge SHALL abort the access; a pending write SHALL NOT be committed.
REQ-030 Reset asserted in RESP SHALL clear ack at that edge; storage keeps the write already committed.
REQ-031 First acceptance SHALL be possible on the first edge with rst_n=1.

Structure
REQ-032 Package wait_ram_pkg SHALL hold the FSM state enum (IDLE, WAIT, RESP) and default parameter constants.
REQ-033 Storage SHALL be sub-module wait_ram_array (DEPTH x DATA_W, synchronous write, registered read, one port).
REQ-034 wait_ram_array SHALL expose its storage to the simulator for bench preload and peek.

Verification
REQ-035 WAIT_CYCLES=1: write 0xA5 to 0x0010 at edge 0 -> ack high after edge 2 only, err=0; read 0x0010 -> rdata=0xA5 with ack.
REQ-036 WAIT_CYCLES=0 and 15: single read -> ack exactly 1 and 16 edges after acceptance respectively; ready=0 in between.
REQ-037 DEPTH=1024: write 0x3C to 0x0400 -> ack with err=1; read 0x0400 -> rdata=0x00 with err=1; read 0x0000 unchanged.
REQ-038 req held high continuously with toggling addr -> exactly one access per WAIT_CYCLES+3 cycles, each using the addr present at its accepting edge.
REQ-039 Write 0x77 to 0x0020 (previously 0x11), rst_n=0 for one edge in WAIT -> ack never rises; later read 0x0020 returns 0x11.
REQ-040 DATA_W=16, ADDR_W=8: write 0xBEEF to 0xFF, read back -> 0xBEEF; rdata stays 0xBEEF through a following write.
